demux_rr_sched: RTL and testbench
=================================

Name: demux_rr_sched

Overview:
- Round-robin scheduler that sequences a 1-to-4 demux datapath: takes one valid/ready input stream and routes bursts to four sinks.
- Generates the demux select lines (s1,s0) and holds them stable for a whole burst.
- Owns a one-beat registered output stage, so the demux select never changes under an in-flight beat.
- Sits between a single producer and four consumer channels.

Parameters:
- WIDTH, 8, data width in bits.
- BURST, 4, maximum beats per grant; legal range 1..256.

Ports:
- clk  in  1  clock, all state changes on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  producer has a beat.
- in_data  in  WIDTH  producer beat.
- in_last  in  1  beat ends the current burst early.
- in_ready  out  1  scheduler accepts the beat this cycle.
- dst_en  in  4  per-destination enable; bit i = sink i eligible for grant.
- out_data  out  WIDTH  registered beat to the demux.
- out_valid  out  4  one-hot valid, bit = current select.
- out_ready  in  4  per-sink ready.
- s0  out  1  select LSB.
- s1  out  1  select MSB.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE, ptr=3 (first grant goes to sink 0), {s1,s0}=0, out_valid=0, out_data=0, in_ready=0, busy=0, beat count=0.
- rst asserted mid-burst clears everything the same way; the buffered beat is discarded.
- Input transfer: in_valid & in_ready. Output transfer: out_valid[sel] & out_ready[sel].
- IDLE:
  - in_ready=0.
  - in_valid=1 -> ARB next cycle.
- ARB:
  - in_ready=0.
  - Search sinks ptr+1, ptr+2, ptr+3, ptr (mod 4) for the first with dst_en=1.
  - On a hit: sel <= that sink, count <= 0, -> XFER.
  - On no hit: stay in ARB.
  - ARB always lasts at least 1 cycle.
- XFER:
  - in_ready = !out_full | out_ready[sel].
  - Each input transfer loads out_data, sets out_valid[sel], and increments count.
  - An output transfer with no input transfer clears out_valid.
  - Simultaneous input and output transfers give back-to-back beats with no bubble.
  - Burst ends on the input transfer where count reaches BURST-1 or in_last=1.
  - At burst end: in_ready drops next cycle, -> DRAIN.
- DRAIN:
  - in_ready=0.
  - When out_full=0 (or clears this cycle): ptr <= sel.
  - Then -> ARB if in_valid, else IDLE.
- Latency: input beat appears on out_data/out_valid the cycle after acceptance.
- Select stability: sel, s1, s0 change only in ARB, and only while out_valid=0.
- dst_en changes during XFER or DRAIN are ignored until the next ARB.
- A disabled sink is skipped; a single enabled sink receives consecutive bursts, each separated by one ARB cycle.
- Count width is clog2(BURST) with a minimum of 1. BURST=1 means every beat ends its burst.
- out_ready bits for unselected sinks are ignored.

Optional Feature:
- Macro: DEMUX_RR_SCHED_STATS_EN.
- Defined:
  - Adds input stat_clr (1) and output stat_cnt (64).
  - stat_cnt holds four 16-bit counters, sink i at bits [16i+15:16i].
  - Each output transfer to sink i increments its counter, saturating at 16'hFFFF.
  - rst or stat_clr clears all counters; clear has priority over an increment in the same cycle.
- Undefined:
  - The ports are absent and no counter logic exists.
  - All other behaviour is identical.

Test Plan:
- Reset, all dst_en=1, out_ready=4'hF, 12 continuous beats 0x01..0x0C:
  - 0x01-0x04 go to sink 0 with {s1,s0}=00, 0x05-0x08 to sink 1, 0x09-0x0C to sink 2.
  - ARB/DRAIN gaps appear between bursts; out_valid is always one-hot.
- dst_en=4'b1010, 8 beats:
  - Bursts go to sink 1, then sink 3.
  - out_valid[0] and out_valid[2] never assert.
- in_last on beat 2 of a burst to sink 0:
  - Burst ends after 2 beats; next burst goes to sink 1.
- out_ready[0]=0 for 5 cycles after the first beat:
  - out_data holds 0x01, in_ready=0, s0/s1 stay stable.
  - When ready returns, beats resume with no loss or duplication.
- dst_en=0 with in_valid=1:
  - Scheduler stays in ARB, in_ready=0, busy=1.
  - Setting dst_en=4'b0100 grants sink 2 the next cycle.
- rst pulsed mid-burst with a beat buffered:
  - out_valid=0 and busy=0 the next cycle.
  - The following burst goes to sink 0.
  - With STATS_EN, all counters read 0.

Source files
------------

// File: rtl/demux_rr_sched.sv
// demux_rr_sched: round-robin burst scheduler driving a 1-to-4 demux with a one-beat output register.
// Optional per-sink transfer counters are enabled by defining DEMUX_RR_SCHED_STATS_EN.
module demux_rr_sched #(
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
`ifdef DEMUX_RR_SCHED_STATS_EN
    input  logic             stat_clr,
    output logic [63:0]      stat_cnt,
`endif
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    input  logic [3:0]       dst_en,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic             s0,
    output logic             s1,
    output logic             busy
);
    localparam int CW = BURST > 1 ? $clog2(BURST) : 1;

    typedef enum logic [1:0] {IDLE, ARB, XFER, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d, sel_q, sel_d, hit;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full_q, full_d, found, in_xfer, out_xfer;
    logic [WIDTH-1:0] data_q, data_d;

    assign out_xfer  = full_q & out_ready[sel_q];
    assign in_ready  = (state_q == XFER) && (!full_q || out_ready[sel_q]);
    assign in_xfer   = in_valid & in_ready;
    assign out_data  = data_q;
    assign out_valid = full_q ? 4'b0001 << sel_q : 4'b0000;
    assign {s1, s0}  = sel_q;
    assign busy      = state_q != IDLE;

    // Descending scan so the nearest enabled sink after ptr wins; offset 4 wraps to ptr itself.
    always_comb begin
        found = 1'b0;
        hit   = ptr_q;
        for (int k = 4; k >= 1; k--) begin
            if (dst_en[ptr_q + 2'(k)]) begin
                found = 1'b1;
                hit   = ptr_q + 2'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = in_xfer ? cnt_q + CW'(1) : cnt_q;
        data_d  = in_xfer ? in_data : data_q;
        full_d  = in_xfer | (full_q & !out_xfer);
        case (state_q)
            IDLE:  state_d = in_valid ? ARB : IDLE;
            ARB: begin
                if (found) begin
                    sel_d   = hit;
                    cnt_d   = '0;
                    state_d = XFER;
                end
            end
            XFER:  state_d = (in_xfer && (in_last || cnt_q == CW'(BURST - 1))) ? DRAIN : XFER;
            DRAIN: begin
                if (!full_q || out_xfer) begin
                    ptr_d   = sel_q;
                    state_d = in_valid ? ARB : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd3;
            sel_q   <= 2'd0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            data_q  <= data_d;
        end
    end

`ifdef DEMUX_RR_SCHED_STATS_EN
    logic [63:0] stat_q;

    assign stat_cnt = stat_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst || stat_clr)
                stat_q[16*i +: 16] <= '0;
            else if (out_xfer && sel_q == 2'(i) && stat_q[16*i +: 16] != 16'hFFFF)
                stat_q[16*i +: 16] <= stat_q[16*i +: 16] + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_demux_rr_sched.sv
// tb_demux_rr_sched: directed stimulus with a scoreboard queue checked by an independent output monitor.
module tb_demux_rr_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [3:0] dst_en = 4'hF;
    logic [7:0] out_data;
    logic [3:0] out_valid;
    logic [3:0] out_ready = 4'hF;
    logic       s0, s1, busy;
`ifdef DEMUX_RR_SCHED_STATS_EN
    logic        stat_clr = 1'b0;
    logic [63:0] stat_cnt;
`endif

    int         n_chk = 0;
    int         n_err = 0;
    logic [3:0] forbid = 4'h0;
    logic [9:0] sb[$];

    demux_rr_sched dut (
`ifdef DEMUX_RR_SCHED_STATS_EN
        .stat_clr (stat_clr),
        .stat_cnt (stat_cnt),
`endif
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .dst_en   (dst_en),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s0       (s0),
        .s1       (s1),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one beat; expected {sink,data} is queued at the cycle the DUT accepts it.
    task automatic send(input logic [7:0] d, input logic l, input logic [1:0] s);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            n_chk++;
            n_err++;
            $display("FAIL accept_timeout: beat %0h never accepted", d);
        end else
            sb.push_back({s, d});
        @(negedge clk);
    endtask

    task automatic idle_wait();
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (6) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every output transfer.
    initial begin
        logic [1:0] sel;
        logic [9:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid != 4'h0) begin
                sel = {s1, s0};
                chk("onehot", out_valid, 4'b0001 << sel);
                if ((out_valid & forbid) != 4'h0) chk("forbidden_sink", out_valid & forbid, 0);
                if (out_ready[sel]) begin
                    if (sb.size() == 0) chk("unexpected_beat", {sel, out_data}, 0);
                    else begin
                        e = sb.pop_front();
                        chk("beat_data", out_data, e[7:0]);
                        chk("beat_sink", sel, e[9:8]);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset();
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sel", {s1, s0}, 0);
        @(negedge clk);

        // Three full bursts rotating through sinks 0,1,2.
        for (int i = 1; i <= 12; i++) send(8'(i), 1'b0, 2'((i - 1) / 4));
        idle_wait();

        // Only sinks 1 and 3 enabled.
        do_reset();
        dst_en = 4'b1010;
        forbid = 4'b0101;
        for (int i = 1; i <= 8; i++) send(8'h10 + 8'(i), 1'b0, i <= 4 ? 2'd1 : 2'd3);
        idle_wait();
        forbid = 4'h0;

        // Early termination with in_last on the second beat.
        do_reset();
        dst_en = 4'hF;
        send(8'h21, 1'b0, 2'd0);
        send(8'h22, 1'b1, 2'd0);
        for (int i = 3; i <= 6; i++) send(8'h20 + 8'(i), 1'b0, 2'd1);
        idle_wait();

        // Backpressure on sink 0 with a beat held in the output register.
        do_reset();
        send(8'h01, 1'b0, 2'd0);
        out_ready = 4'hE;
        in_valid  = 1'b1;
        in_data   = 8'h02;
        repeat (5) begin
            #1;
            chk("stall_data", out_data, 8'h01);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_sel", {s1, s0}, 0);
            @(negedge clk);
        end
        out_ready = 4'hF;
        send(8'h02, 1'b0, 2'd0);
        send(8'h03, 1'b0, 2'd0);
        send(8'h04, 1'b0, 2'd0);
        send(8'h05, 1'b1, 2'd1);
        idle_wait();

        // No eligible sink: parked in ARB until one is enabled.
        do_reset();
        dst_en   = 4'h0;
        in_valid = 1'b1;
        in_data  = 8'h40;
        in_last  = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("noen_busy", busy, 1);
        chk("noen_in_ready", in_ready, 0);
        chk("noen_out_valid", out_valid, 0);
        @(negedge clk);
        dst_en = 4'b0100;
        @(negedge clk);
        #1;
        chk("grant_sel", {s1, s0}, 2);
        chk("grant_in_ready", in_ready, 1);
        send(8'h40, 1'b1, 2'd2);
        idle_wait();

        // Reset mid-burst discards the buffered beat and restores the pointer.
        do_reset();
        dst_en = 4'hF;
        send(8'h50, 1'b1, 2'd0);
        idle_wait();
        out_ready = 4'h0;
        send(8'h51, 1'b0, 2'd1);
        #1;
        chk("pre_rst_out_valid", out_valid, 4'b0010);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        #1;
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_busy", busy, 0);
`ifdef DEMUX_RR_SCHED_STATS_EN
        chk("post_rst_stats", stat_cnt[31:0], 0);
        chk("post_rst_stats_hi", stat_cnt[63:32], 0);
`endif
        out_ready = 4'hF;
        @(negedge clk);
        send(8'h61, 1'b1, 2'd0);
        idle_wait();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
